// File: rtl/hough_vote_accumulator.sv
// Hough vote accumulator: clears the external accumulator BRAM and applies one
// saturating read-modify-write increment per (r, angle) pair of a vote burst.
module hough_vote_accumulator #(
    parameter int COUNT_WIDTH = 16,
    parameter int N_VOTES     = 45,
    parameter int R_MAX       = 800
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   start_transmit,
    input  logic [12:0]            transmit_r,
    input  logic [7:0]             transmit_angle,
    output logic [14:0]            mem_addr,
    output logic                   mem_we,
    output logic [COUNT_WIDTH-1:0] mem_wdata,
    input  logic [COUNT_WIDTH-1:0] mem_rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   drop_err,
    output logic [1:0]             dbg_state
);

    localparam logic [6:0]         LAST_CNT = 7'(2 * N_VOTES);
    localparam logic [7:0]         ANG_MAX  = 8'(4 * (N_VOTES - 1));
    localparam logic signed [13:0] RMAX     = 14'(R_MAX);
    localparam logic [14:0]        CLR_LAST = '1;
    localparam logic [COUNT_WIDTH-1:0] ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RECV  = 2'd2
    } state_t;

    state_t      r_state, w_next;
    logic [6:0]  r_cnt;
    logic [14:0] r_clr_addr;
    logic [12:0] r_r;
    logic [7:0]  r_ang;
    logic        r_valid, r_done, r_drop;

    logic               w_done_next, w_sample, w_write, w_in_valid;
    logic signed [13:0] w_in_r, w_sum;
    logic [8:0]         w_ridx;

    // Handshake: the sender holds each pair for two cycles after start_transmit;
    // r_cnt even = sample slot (plus write of the previous pair), r_cnt odd = read slot.
    assign w_in_r     = $signed({transmit_r[12], transmit_r});
    assign w_in_valid = (transmit_angle <= ANG_MAX) && (transmit_angle[1:0] == 2'b00)
                        && (w_in_r >= -RMAX) && (w_in_r <= RMAX);
    assign w_sum      = $signed({r_r[12], r_r}) + RMAX;
    assign w_ridx     = w_sum[10:2];
    assign w_sample   = (r_state == ST_RECV) && !r_cnt[0] && (r_cnt != LAST_CNT);
    assign w_write    = (r_state == ST_RECV) && !r_cnt[0] && (r_cnt != 7'd0) && r_valid;

    always_comb begin
        w_next      = r_state;
        w_done_next = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        case (r_state)
            ST_IDLE: begin
                if (start_transmit) w_next = ST_RECV;
            end
            ST_CLEAR: begin
                mem_addr = r_clr_addr;
                mem_we   = 1'b1;
                if (r_clr_addr == CLR_LAST) begin
                    w_next      = ST_IDLE;
                    w_done_next = 1'b1;
                end
            end
            ST_RECV: begin
                mem_addr = {r_ang[7:2], w_ridx};
                if (w_write) begin
                    mem_we    = 1'b1;
                    mem_wdata = (&mem_rdata) ? mem_rdata : mem_rdata + ONE;
                end
                if (r_cnt == LAST_CNT) begin
                    w_next      = ST_IDLE;
                    w_done_next = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // A clear aborts whatever is running and suppresses its done.
        if (clear) begin
            w_next      = ST_CLEAR;
            w_done_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_clr_addr <= '0;
            r_r        <= '0;
            r_ang      <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_done     <= w_done_next;
            r_cnt      <= (r_state == ST_RECV && w_next == ST_RECV) ? r_cnt + 7'd1 : 7'd0;
            r_clr_addr <= (r_state == ST_CLEAR && !clear) ? r_clr_addr + 15'd1 : 15'd0;
            if (w_sample && !clear) begin
                r_r     <= transmit_r;
                r_ang   <= transmit_angle;
                r_valid <= w_in_valid;
            end
            if (clear && r_state == ST_IDLE)
                r_drop <= 1'b0;
            else if ((start_transmit && r_state != ST_IDLE) || (w_sample && !clear && !w_in_valid))
                r_drop <= 1'b1;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign drop_err  = r_drop;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_hough_vote_accumulator.sv
// Bench for hough_vote_accumulator: owns the accumulator memory, predicts every
// write/busy/done from the vote rules and compares each cycle.
module tb_hough_vote_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        start_transmit = 1'b0;
    logic [12:0] transmit_r = '0;
    logic [7:0]  transmit_angle = '0;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        busy, done, drop_err;
    logic [1:0]  dbg_state;

    hough_vote_accumulator dut (
        .clk(clk), .reset(reset), .clear(clear), .start_transmit(start_transmit),
        .transmit_r(transmit_r), .transmit_angle(transmit_angle),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .drop_err(drop_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator memory and the model's view of it
    logic [15:0] mem     [32768] = '{default: 16'h0};
    logic [15:0] ref_mem [32768] = '{default: 16'h0};
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
        mem_rdata <= mem[mem_addr];
    end

    logic [14:0] exp_we [int];
    bit          exp_busy [int];
    bit          exp_done [int];
    int clr_lo = -1, clr_hi = -1, clr_writes = 0;
    bit chk_en = 1'b0;
    int n_checks = 0, n_fail = 0;
    int burst_r [45];
    int burst_a [45];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pair_ok(input int r, input int a);
        return (a >= 0) && (a <= 176) && (a % 4 == 0) && (r >= -800) && (r <= 800);
    endfunction

    function automatic int bin_addr(input int r, input int a);
        return (a / 4) * 512 + (r + 800) / 4;
    endfunction

    function automatic int hough_r(input int x, input int y, input int a);
        real th;
        th = a * 3.14159265358979 / 180.0;
        return int'(x * $cos(th) + y * $sin(th));
    endfunction

    task automatic load_pixel(input int x, input int y);
        for (int k = 0; k < 45; k++) begin
            burst_a[k] = 4 * k;
            burst_r[k] = hough_r(x, y, 4 * k);
        end
    endtask

    task automatic load_random();
        int x, y;
        x = int'($urandom_range(0, 560));
        y = int'($urandom_range(0, 560));
        load_pixel(x, y);
        for (int k = 0; k < 45; k++)
            if ($urandom_range(0, 3) == 0) burst_r[k] = int'($urandom_range(0, 1600)) - 800;
    endtask

    task automatic schedule(input int s);
        for (int k = 0; k < 45; k++)
            if (pair_ok(burst_r[k], burst_a[k])) exp_we[s + 3 + 2 * k] = 15'(bin_addr(burst_r[k], burst_a[k]));
        for (int c = s + 1; c <= s + 91; c++) exp_busy[c] = 1'b1;
        exp_done[s + 92] = 1'b1;
    endtask

    task automatic cancel_after(input int c);
        int keys[$];
        foreach (exp_we[k]) if (k > c) keys.push_back(k);
        foreach (keys[i]) exp_we.delete(keys[i]);
        keys.delete();
        foreach (exp_busy[k]) if (k > c) keys.push_back(k);
        foreach (keys[i]) exp_busy.delete(keys[i]);
        keys.delete();
        foreach (exp_done[k]) if (k > c) keys.push_back(k);
        foreach (keys[i]) exp_done.delete(keys[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst();
        int s;
        step();
        s = cyc;
        start_transmit = 1'b1;
        schedule(s);
        step();
        start_transmit = 1'b0;
        for (int k = 0; k < 45; k++) begin
            transmit_r     = 13'(burst_r[k]);
            transmit_angle = 8'(burst_a[k]);
            step();
            step();
        end
        repeat (3) step();
    endtask

    // Per-cycle compare against the model
    logic        in_clr, e_we, e_busy, e_done;
    logic [14:0] e_addr;
    logic [15:0] e_data;

    always @(negedge clk) begin
        if (chk_en) begin
            in_clr = (clr_lo >= 0) && (cyc >= clr_lo) && (cyc <= clr_hi);
            e_we   = 1'b0;
            e_addr = '0;
            e_data = '0;
            if (in_clr) begin
                e_we   = 1'b1;
                e_addr = 15'(cyc - clr_lo);
            end else if (exp_we.exists(cyc) != 0) begin
                e_we   = 1'b1;
                e_addr = exp_we[cyc];
                e_data = (ref_mem[e_addr] == 16'hFFFF) ? 16'hFFFF : ref_mem[e_addr] + 16'd1;
            end
            chk("mem_we", 32'(mem_we), 32'(e_we));
            if (e_we) begin
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(e_data));
                ref_mem[e_addr] = e_data;
                if (in_clr && mem_we) clr_writes++;
            end
            e_busy = in_clr || (exp_busy.exists(cyc) != 0);
            e_done = (exp_done.exists(cyc) != 0) || (clr_hi >= 0 && cyc == clr_hi + 1);
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            if (pre_we) ref_mem[pre_addr] = pre_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, nz, nm;
        repeat (3) step();
        @(negedge clk);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_drop", 32'(drop_err), 0);
        step();
        reset  = 1'b0;
        chk_en = 1'b1;
        step();

        // Pixel (3,4): hand-computed anchors for the model
        load_pixel(3, 4);
        chk("model_r_a0", burst_r[0], 3);
        chk("model_addr_a0", bin_addr(burst_r[0], 0), 200);
        chk("model_r_a88", burst_r[22], 4);
        chk("model_addr_a88", bin_addr(burst_r[22], 88), 11465);
        run_burst();
        chk("bin_a0_once", 32'(mem[15'd200]), 1);
        chk("bin_a88_once", 32'(mem[15'd11465]), 1);
        run_burst();
        run_burst();
        for (int k = 0; k < 45; k++)
            chk("bin_x3", 32'(mem[15'(bin_addr(burst_r[k], burst_a[k]))]), 3);

        // Saturation
        pre_addr = 15'd200;
        pre_data = 16'hFFFF;
        pre_we   = 1'b1;
        step();
        pre_we = 1'b0;
        run_burst();
        chk("bin_sat", 32'(mem[15'd200]), 32'h0000FFFF);
        chk("bin_a88_x4", 32'(mem[15'd11465]), 4);
        chk("drop_after_valid", 32'(drop_err), 0);

        // Randomized valid bursts
        repeat (3) begin
            load_random();
            run_burst();
            chk("drop_random", 32'(drop_err), 0);
        end

        // start_transmit while busy
        load_random();
        fork
            run_burst();
            begin
                step();
                repeat (10) step();
                start_transmit = 1'b1;
                step();
                start_transmit = 1'b0;
            end
        join
        chk("drop_conflict", 32'(drop_err), 1);

        // Reset mid-burst, then a normal burst
        load_random();
        fork
            run_burst();
            begin
                step();
                repeat (30) step();
                reset = 1'b1;
                cancel_after(cyc);
                step();
                reset = 1'b0;
                @(negedge clk);
                chk("rst_mid_addr", 32'(mem_addr), 0);
                chk("rst_mid_wdata", 32'(mem_wdata), 0);
                chk("rst_mid_drop", 32'(drop_err), 0);
            end
        join
        load_random();
        run_burst();
        chk("drop_after_reset", 32'(drop_err), 0);

        // Invalid pairs
        load_pixel(int'($urandom_range(0, 560)), int'($urandom_range(0, 560)));
        burst_r[5] = 900;
        burst_a[6] = 178;
        burst_r[7] = -801;
        nv = 0;
        for (int k = 0; k < 45; k++) if (pair_ok(burst_r[k], burst_a[k])) nv++;
        chk("model_n_valid", nv, 42);
        run_burst();
        chk("drop_invalid", 32'(drop_err), 1);

        // Clear aborting a burst, full clear runs
        load_random();
        fork
            run_burst();
            begin
                step();
                repeat (20) step();
                clear = 1'b1;
                cancel_after(cyc);
                clr_lo = cyc + 1;
                clr_hi = cyc + 32768;
                step();
                clear = 1'b0;
            end
        join
        while (cyc <= clr_hi + 3) step();
        chk("clear_writes", clr_writes, 32768);
        nz = 0;
        nm = 0;
        for (int i = 0; i < 32768; i++) begin
            if (mem[i] != 16'h0) nz++;
            if (mem[i] != ref_mem[i]) nm++;
        end
        chk("clear_nonzero", nz, 0);
        chk("mem_vs_model", nm, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hough_vote_accumulator.md
# hough_vote_accumulator

Receiving end of the Hough vote stream. Consumes the 45 (r, angle) pairs that the per-pixel Hough calculator emits after its `start_transmit` pulse, and performs one saturating read-modify-write increment per pair on the external accumulator BRAM. Also clears the whole accumulator before a frame. Sits between the calculator and the accumulator memory that the peak finder later scans.

## Interface
Parameters:
- `COUNT_WIDTH`, 16: vote counter width per bin
- `N_VOTES`, 45: pairs per transmission (angles 0..176 step 4)
- `R_MAX`, 800: maximum |r|; valid r is -R_MAX..R_MAX

Ports:
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `clear` in 1: one-cycle pulse, zero the entire accumulator
- `start_transmit` in 1: one-cycle pulse from the calculator, precedes a 45-pair burst
- `transmit_r` in 13: signed r of the current pair
- `transmit_angle` in 8: angle in degrees of the current pair
- `mem_addr` out 15: accumulator address `{angle[7:2], r_idx[8:0]}`, with r_idx = (r + R_MAX) >> 2
- `mem_we` out 1: write enable
- `mem_wdata` out COUNT_WIDTH: write data
- `mem_rdata` in COUNT_WIDTH: read data, valid the cycle after the address is presented (1-cycle BRAM latency)
- `busy` out 1: clear or burst in progress
- `done` out 1: one-cycle pulse after the last clear write or the last vote slot
- `drop_err` out 1: sticky; a vote or command was discarded

## Operation
- States:
  - IDLE
  - CLEAR
  - RECV: alternating SAMPLE/READ/WRITE slots
- IDLE + `clear`: enter CLEAR, and clear `drop_err`.
- IDLE + `start_transmit`: enter RECV with slot k = 0.
- CLEAR:
  - Drive `mem_we`=1 and `mem_wdata`=0, with `mem_addr` stepping 0..32767, one address per cycle.
  - After address 32767 is written, return to IDLE and pulse `done`.
- RECV, per pair k:
  - Sample `transmit_r` and `transmit_angle` into registers.
  - Validity check: angle ≤ 176, angle[1:0] = 0, and -R_MAX ≤ r ≤ R_MAX.
  - Valid pair:
    - Read cycle: present the address with `mem_we`=0.
    - Write cycle: same address, `mem_we`=1, `mem_wdata` = `mem_rdata` + 1.
    - Saturate: if `mem_rdata` is all ones, write all ones.
  - Invalid pair: the slot is still consumed, `mem_we` stays 0, and `drop_err` is set.
  - After k = 44, return to IDLE and pulse `done`.
- Priority and conflict rules:
  - `reset` overrides everything.
  - `clear` in any state aborts the current activity, restarts CLEAR at address 0, and gives no `done` for the aborted burst.
  - `start_transmit` while busy (CLEAR or RECV) is ignored and sets `drop_err`.
- r_idx arithmetic:
  - Computed in 14-bit signed: r + 800 yields 0..1600; r_idx is bits [10:2], range 0..400.
  - Angle index is bits [7:2], range 0..44.

## Timing
- Let S be the cycle in which `start_transmit` is high. The sender holds pair k stable during cycles S+1+2k and S+2+2k.
- Pair k:
  - sampled at the end of cycle S+1+2k
  - read address driven in S+2+2k
  - write in S+3+2k
- One vote per 2 cycles, matching the sender rate. Vote slots never overlap, so there is no read/write hazard.
- `busy`:
  - RECV: high S+1 through S+91
  - CLEAR: high from the cycle after `clear` for 32768 cycles
- `done` timing:
  - RECV: `done`=1 in S+92
  - CLEAR: `done`=1 the cycle after the final clear write
- Reset values: `mem_addr`=0, `mem_we`=0, `mem_wdata`=0, `busy`=0, `done`=0, `drop_err`=0; state IDLE.
- Reset mid-burst or mid-clear: memory is left partially updated, no `done` is issued, and the next `start_transmit` is accepted normally.
- `mem_we` is never high outside CLEAR write cycles or RECV write cycles.

## Test plan
- Clear:
  - Stimulus: `clear` pulse.
  - Required: exactly 32768 writes of 0 at addresses 0..32767, `busy` high for 32768 cycles, `done` one cycle after the last write.
  - Model memory all zero afterwards.
- Single burst:
  - Stimulus: calculator-style burst for pixel (x=3, y=4) after a clear.
  - Required: 45 reads and 45 writes.
  - Angle 0: r=3 gives address {6'd0, 9'd200} written with 1.
  - Angle 88: r≈4 gives address {6'd22, 9'd201}.
  - `done` at S+92.
- Repeat and saturation:
  - Repeat the same burst 3 times: each of the 45 bins reads 3.
  - Preload one bin with 0xFFFF, then vote it: it stays 0xFFFF.
- Invalid pairs:
  - Stimulus: burst with k=5 r=900, k=6 angle=178, k=7 r=-801.
  - Required: those three slots show no `mem_we`, `drop_err`=1, and the other 42 bins increment.
- Conflicts:
  - `start_transmit` at S+10 during a burst: ignored, `drop_err` set, `done` still at S+92.
  - `clear` at S+20: burst aborted, no `done` at S+92, full clear runs.
- Reset:
  - Stimulus: `reset` at S+30.
  - Required: all outputs 0 the next cycle, and a subsequent burst completes with `done` at S'+92.
